// File: rtl/types_pkg.sv
// Shared types for the memory responder slice.
//   word_t            : 32-bit data/address word
//   wstrobe_t         : per-byte write enables, all-zero means read
//   responder_state_t : responder FSM states
package types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = WORD_W / 8;
    localparam int unsigned COUNT_W = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANES-1:0]  wstrobe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } responder_state_t;

endpackage

// File: rtl/memory_responder_if.sv
// Initiator/responder memory bus.
//   valid   : initiator requests a transfer
//   ready   : one-cycle completion pulse from the responder
//   address : byte address
//   wstrobe : byte-lane write enables (zero = read)
//   wdata   : lane-replicated write data
//   rdata   : full aligned read word
//   error   : raised with ready for an out-of-range access
interface memory_responder_if;
    import types_pkg::*;

    logic     valid;
    logic     ready;
    word_t    address;
    wstrobe_t wstrobe;
    word_t    wdata;
    word_t    rdata;
    logic     error;

    modport master (
        output valid, address, wstrobe, wdata,
        input  ready, rdata, error
    );

    modport slave (
        input  valid, address, wstrobe, wdata,
        output ready, rdata, error
    );

endinterface

// File: rtl/byte_enable_ram.sv
// Word-wide RAM with per-byte write enables and a registered read-old port.
//   clk   : clock
//   en    : load the output register from mem[addr]
//   clr   : clear the output register (wins over en)
//   we    : byte-lane write enables for mem[addr]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module byte_enable_ram
    import types_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     clr,
    input  wstrobe_t                 we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  word_t                    wdata,
    output word_t                    rdata
);

    word_t mem [DEPTH];

    // Per-lane write; old contents stay visible to the read on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register: cleared on reset/out-of-range, otherwise holds.
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: valid/ready slave with configurable wait states,
// base-relative address decode and byte-lane writes into a local RAM.
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of memory_responder_if
module memory_responder
    import types_pkg::*;
#(
    parameter int unsigned SIZE         = 256,
    parameter word_t       BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned LATENCY      = 0,
    parameter string       INIT_FILE    = ""
) (
    input  logic               clk,
    input  logic               reset_n,
    memory_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(SIZE);

    responder_state_t     state, state_next;
    logic [COUNT_W-1:0]   count, count_next;
    logic [WORD_W-3:0]    word_off;
    logic [IDX_W-1:0]     index;
    logic                 in_range;
    logic                 capture;

    // Address decode; address[1:0] only affects the unused byte offset.
    assign word_off = (WORD_W-2)'((bus.address - BASE_ADDRESS) >> 2);
    assign in_range = (bus.address >= BASE_ADDRESS) && (word_off < (WORD_W-2)'(SIZE));
    assign index    = word_off[IDX_W-1:0];

    // Request fields are taken only on the edge that enters DONE.
    assign capture = reset_n && (state_next == DONE);

    // State, counter and response flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            bus.ready <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            bus.ready <= (state_next == DONE);
            bus.error <= (state_next == DONE) && !in_range;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (bus.valid) begin
                    if (LATENCY == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        count_next = COUNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (!bus.valid) begin
                    // Initiator withdrew mid-request: abandon it silently.
                    state_next = IDLE;
                    count_next = '0;
                end else if (count == '0) begin
                    state_next = DONE;
                end else begin
                    count_next = count - COUNT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    byte_enable_ram #(
        .DEPTH     (SIZE),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (capture && in_range),
        .clr   (!reset_n || (capture && !in_range)),
        .we    ((capture && in_range) ? bus.wstrobe : wstrobe_t'(0)),
        .addr  (index),
        .wdata (bus.wdata),
        .rdata (bus.rdata)
    );

endmodule
